ddr2_rd_arbiter: RTL and testbench

//  Shares the single ddr2_mgr read port (rd_mem_req/addr/xfr_len/grant/data/valid) between
//  NUM_REQ read clients, e.g. the frame-buffer line fetcher and the fractal/verify reader.

---
 rtl/ddr2_rd_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/ddr2_rd_arbiter.sv | 158 +++++++++++++++
 tb/tb_ddr2_rd_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_rd_arb_pkg.sv
// Shared types and default widths for the ddr2_mgr read-port arbiter.
package ddr2_rd_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StXfr  = 2'b10,
    StDone = 2'b11
  } state_e;

  localparam int unsigned DefAddrW      = 25;
  localparam int unsigned DefLenW       = 10;
  localparam int unsigned DefDataW      = 32;
  localparam int unsigned DefTimeoutCyc = 4095;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  localparam int unsigned CandW = IdxW + 1;

  logic [CandW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = {1'b0, ptr_i} + CandW'(off);
      if (cand >= CandW'(NumReq)) begin
        cand = cand - CandW'(NumReq);
      end
      if (!valid_o && req_i[cand[IdxW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IdxW-1:0];
      end
    end
    if (valid_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/ddr2_rd_arbiter.sv
// Shares the ddr2_mgr read port between NUM_REQ clients, one burst at a time, round-robin,
// with beat counting, overrun dropping and a per-beat watchdog abort.
module ddr2_rd_arbiter
  import ddr2_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned LEN_W       = DefLenW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        cli_req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] cli_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]  cli_len_i,
  output logic [NUM_REQ-1:0]        cli_gnt_o,
  output logic [NUM_REQ-1:0]        cli_valid_o,
  output logic [DATA_W-1:0]         cli_data_o,
  output logic [NUM_REQ-1:0]        cli_done_o,
  output logic                      mem_req_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [LEN_W-1:0]          mem_len_o,
  input  logic                      mem_grant_i,
  input  logic [DATA_W-1:0]         mem_data_i,
  input  logic                      mem_data_valid_i,
  output logic                      busy_o,
  output logic                      err_timeout_o
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WdW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  state_e             state_q;
  logic [IdxW-1:0]    ptr_q, owner_q;
  logic [NUM_REQ-1:0] owner_oh_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q, beat_q;
  logic [WdW-1:0]     wdog_q;
  logic               mem_req_q, err_q;
  logic [NUM_REQ-1:0] gnt_q, valid_q, done_q;
  logic [DATA_W-1:0]  data_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i   (cli_req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr = cli_addr_i[i*ADDR_W +: ADDR_W];
        sel_len  = cli_len_i[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      owner_oh_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      wdog_q     <= '0;
      mem_req_q  <= 1'b0;
      err_q      <= 1'b0;
      gnt_q      <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      data_q     <= '0;
    end else begin
      gnt_q   <= '0;
      valid_q <= '0;
      done_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            owner_q    <= arb_idx;
            owner_oh_q <= arb_gnt;
            addr_q     <= sel_addr;
            len_q      <= sel_len;
            gnt_q      <= arb_gnt;
            beat_q     <= '0;
            wdog_q     <= '0;
            // Zero-length bursts never touch the memory port.
            if (sel_len == '0) begin
              done_q  <= arb_gnt;
              state_q <= StDone;
            end else begin
              mem_req_q <= 1'b1;
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_grant_i) begin
            mem_req_q <= 1'b0;
            wdog_q    <= '0;
            state_q   <= StXfr;
          end
        end
        StXfr: begin
          // A beat wins over a coinciding watchdog expiry.
          if (mem_data_valid_i) begin
            data_q  <= mem_data_i;
            valid_q <= owner_oh_q;
            beat_q  <= beat_q + 1'b1;
            wdog_q  <= '0;
            if (beat_q + 1'b1 == len_q) begin
              done_q  <= owner_oh_q;
              state_q <= StDone;
            end
          end else if (wdog_q >= WdLast) begin
            err_q   <= 1'b1;
            done_q  <= owner_oh_q;
            state_q <= StDone;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StDone: begin
          ptr_q   <= (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cli_gnt_o     = gnt_q;
  assign cli_valid_o   = valid_q;
  assign cli_data_o    = data_q;
  assign cli_done_o    = done_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = addr_q;
  assign mem_len_o     = len_q;
  assign busy_o        = (state_q != StIdle);
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_ddr2_rd_arbiter.sv
// Scenario bench for ddr2_rd_arbiter: a small ddr2_mgr read-port model plus grant/beat scoreboards.
module tb_ddr2_rd_arbiter;

  localparam int NR = 2;
  localparam int AW = 25;
  localparam int LW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    cli_req;
  logic [NR*AW-1:0] cli_addr;
  logic [NR*LW-1:0] cli_len;
  logic [NR-1:0]    cli_gnt, cli_valid, cli_done;
  logic [DW-1:0]    cli_data;
  logic             mem_req, mem_grant, mem_data_valid, busy, err_timeout;
  logic [AW-1:0]    mem_addr;
  logic [LW-1:0]    mem_len;
  logic [DW-1:0]    mem_data;

  ddr2_rd_arbiter #(
    .NUM_REQ     (NR),
    .ADDR_W      (AW),
    .LEN_W       (LW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cli_req_i        (cli_req),
    .cli_addr_i       (cli_addr),
    .cli_len_i        (cli_len),
    .cli_gnt_o        (cli_gnt),
    .cli_valid_o      (cli_valid),
    .cli_data_o       (cli_data),
    .cli_done_o       (cli_done),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_len_o        (mem_len),
    .mem_grant_i      (mem_grant),
    .mem_data_i       (mem_data),
    .mem_data_valid_i (mem_data_valid),
    .busy_o           (busy),
    .err_timeout_o    (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {int owner; int len;} burst_t;
  typedef struct {int owner; logic [DW-1:0] data; int cyc;} beat_t;

  burst_t exp_q[$];
  beat_t  sb[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  int gnt_cnt = 0, done_cnt = 0, valid_cnt = 0, mreq_cycles = 0;
  int cur_owner = 0, cur_len = 0, cur_got = 0, done_got = 0;
  int last_done_cyc = 0, last_gnt_cyc = 0, last_beat_edge = 0;
  logic [NR-1:0] last_done = '0;
  int rem[NR];

  // ddr2_mgr read-port model
  int mst = 0, mwait = 0, msent = 0;
  int cfg_gdelay = 1, cfg_beats = 0;
  logic [DW-1:0] cfg_base = '0, next_data = '0;
  bit sb_en = 1'b1;

  task automatic step();
    burst_t e;
    beat_t  b;
    @(posedge clk);
    #1;
    cyc++;
    if (cli_gnt !== '0) begin
      gnt_cnt++;
      last_gnt_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL gnt_order: got %b, required no grant", cli_gnt);
      end else begin
        e = exp_q.pop_front();
        if (cli_gnt !== NR'(1 << e.owner))
          $display("FAIL gnt_order: got %b, required %b", cli_gnt, NR'(1 << e.owner));
        else n_pass++;
        cur_owner = e.owner;
        cur_len   = e.len;
        cur_got   = 0;
      end
    end
    if (cli_valid !== '0) begin
      valid_cnt++;
      cur_got++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL beat: got valid=%b data=%h, required no beat", cli_valid, cli_data);
      end else begin
        b = sb.pop_front();
        if (cli_valid !== NR'(1 << b.owner) || cli_data !== b.data || cyc != b.cyc)
          $display("FAIL beat: got valid=%b data=%h cyc=%0d, required valid=%b data=%h cyc=%0d",
                   cli_valid, cli_data, cyc, NR'(1 << b.owner), b.data, b.cyc);
        else n_pass++;
      end
    end
    if (cli_done !== '0) begin
      done_cnt++;
      last_done     = cli_done;
      last_done_cyc = cyc;
      done_got      = cur_got;
    end
    if (mem_req === 1'b1) mreq_cycles++;
    for (int c = 0; c < NR; c++) begin
      if (cli_gnt[c] === 1'b1) begin
        rem[c]--;
        cli_req[c] = (rem[c] > 0);
      end
    end
    mem_grant      = 1'b0;
    mem_data_valid = 1'b0;
    case (mst)
      0: if (mem_req === 1'b1) begin
        mwait = cfg_gdelay;
        mst   = 1;
      end
      1: if (mwait <= 1) begin
        mem_grant = 1'b1;
        mst       = 2;
        msent     = 0;
        next_data = cfg_base;
      end else mwait--;
      default: if (msent < cfg_beats) begin
        mem_data_valid = 1'b1;
        mem_data       = next_data;
        if (sb_en && msent < cur_len) begin
          b.owner = cur_owner;
          b.data  = next_data;
          b.cyc   = cyc + 1;
          sb.push_back(b);
        end
        last_beat_edge = cyc + 1;
        msent++;
        next_data++;
      end else mst = 0;
    endcase
  endtask

  task automatic issue(input int c, input logic [AW-1:0] a, input int l, input int n);
    cli_addr[c*AW +: AW] = a;
    cli_len[c*LW +: LW]  = LW'(l);
    rem[c]               = n;
    cli_req[c]           = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (done_cnt < target) $display("FAIL %s_done: got %0d dones, required %0d", tag, done_cnt, target);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({cli_gnt, cli_valid, cli_done, mem_req, busy, err_timeout} !== '0)
      $display("FAIL reset_ctrl: got %b, required 0",
               {cli_gnt, cli_valid, cli_done, mem_req, busy, err_timeout});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_len, cli_data} !== '0)
      $display("FAIL reset_data: got %h, required 0", {mem_addr, mem_len, cli_data});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int d0 = done_cnt, v0 = valid_cnt;
    cfg_gdelay = 1;
    cfg_beats  = 2;
    cfg_base   = 32'h0000_1000;
    for (int i = 0; i < 6; i++) exp_q.push_back('{owner: i % 2, len: 2});
    issue(0, 25'h100, 2, 3);
    issue(1, 25'h200, 2, 3);
    wait_done(d0 + 6, 300, "rr");
    step();
    n_checks++;
    if (valid_cnt - v0 != 12) $display("FAIL rr_beats: got %0d, required 12", valid_cnt - v0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL rr_drain: got pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int g0 = gnt_cnt, d0 = done_cnt, v0 = valid_cnt, k = 0;
    cfg_gdelay = 3;
    cfg_beats  = 4;
    cfg_base   = 32'hA0;
    exp_q.push_back('{owner: 0, len: 4});
    issue(0, 25'h0001200, 4, 1);
    while (mem_req !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 25'h0001200 || mem_len !== 10'd4)
      $display("FAIL single_memreq: got req=%b addr=%h len=%0d, required 1 0001200 4",
               mem_req, mem_addr, mem_len);
    else n_pass++;
    wait_done(d0 + 1, 100, "single");
    step();
    n_checks++;
    if (gnt_cnt - g0 != 1 || valid_cnt - v0 != 4 || done_cnt - d0 != 1 || last_done !== 2'b01)
      $display("FAIL single_counts: got gnt=%0d beats=%0d done=%0d/%b, required 1 4 1/01",
               gnt_cnt - g0, valid_cnt - v0, done_cnt - d0, last_done);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || sb.size() != 0)
      $display("FAIL single_idle: got busy=%b pending=%0d, required 0 0", busy, sb.size());
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int g0 = gnt_cnt, d0 = done_cnt, m0 = mreq_cycles;
    exp_q.push_back('{owner: 1, len: 0});
    issue(1, 25'h55, 0, 1);
    wait_done(d0 + 1, 20, "zero");
    repeat (3) step();
    n_checks++;
    if (last_done !== 2'b10 || gnt_cnt - g0 != 1 || last_done_cyc < last_gnt_cyc)
      $display("FAIL zero_done: got done=%b gnts=%0d, required 10 1 (done not before gnt)",
               last_done, gnt_cnt - g0);
    else n_pass++;
    n_checks++;
    if (mreq_cycles != m0) $display("FAIL zero_memreq: got %0d req cycles, required 0", mreq_cycles - m0);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int d0 = done_cnt, v0 = valid_cnt;
    cfg_gdelay = 2;
    cfg_beats  = 4;
    cfg_base   = 32'hB0;
    exp_q.push_back('{owner: 0, len: 2});
    issue(0, 25'h300, 2, 1);
    wait_done(d0 + 1, 50, "overrun");
    repeat (6) step();
    n_checks++;
    if (valid_cnt - v0 != 2 || done_got != 2 || sb.size() != 0)
      $display("FAIL overrun_beats: got %0d beats (%0d at done), required 2", valid_cnt - v0, done_got);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    cfg_gdelay = 1;
    cfg_beats  = 1;
    cfg_base   = 32'hC0;
    exp_q.push_back('{owner: 0, len: 3});
    issue(0, 25'h400, 3, 1);
    wait_done(d0 + 1, 100, "timeout");
    n_checks++;
    if (last_done !== 2'b01 || last_done_cyc - last_beat_edge != TO || done_got != 1)
      $display("FAIL timeout_done: got done=%b after %0d clk with %0d beats, required 01 after %0d with 1",
               last_done, last_done_cyc - last_beat_edge, done_got, TO);
    else n_pass++;
    n_checks++;
    if (err_timeout !== 1'b1) $display("FAIL timeout_err: got %b, required 1", err_timeout);
    else n_pass++;
    cfg_beats = 2;
    cfg_base  = 32'hD0;
    exp_q.push_back('{owner: 1, len: 2});
    issue(1, 25'h500, 2, 1);
    wait_done(d0 + 2, 50, "after_timeout");
    step();
    n_checks++;
    if (err_timeout !== 1'b1 || last_done !== 2'b10 || done_got != 2)
      $display("FAIL timeout_sticky: got err=%b done=%b beats=%0d, required 1 10 2",
               err_timeout, last_done, done_got);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt, v0 = valid_cnt, k = 0;
    cfg_gdelay = 1;
    cfg_beats  = 8;
    cfg_base   = 32'hE0;
    exp_q.push_back('{owner: 0, len: 8});
    issue(0, 25'h600, 8, 1);
    while (valid_cnt == v0 && k < 30) begin
      step();
      k++;
    end
    sb_en = 1'b0;
    sb.delete();
    rst = 1'b1;
    step();
    n_checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || cli_done !== '0 || err_timeout !== 1'b0 || k >= 30)
      $display("FAIL midrst_state: got req=%b busy=%b done=%b err=%b, required 0 0 00 0",
               mem_req, busy, cli_done, err_timeout);
    else n_pass++;
    rst = 1'b0;
    v0  = valid_cnt;
    repeat (10) step();
    n_checks++;
    if (valid_cnt != v0 || done_cnt != d0 || mst != 0)
      $display("FAIL midrst_drop: got beats=%0d dones=%0d, required 0 0", valid_cnt - v0, done_cnt - d0);
    else n_pass++;
    sb_en     = 1'b1;
    cfg_beats = 2;
    cfg_base  = 32'hF0;
    exp_q.push_back('{owner: 1, len: 2});
    issue(1, 25'h700, 2, 1);
    wait_done(d0 + 1, 50, "midrst_fresh");
    step();
    n_checks++;
    if (last_done !== 2'b10 || done_got != 2 || busy !== 1'b0)
      $display("FAIL midrst_fresh: got done=%b beats=%0d busy=%b, required 10 2 0",
               last_done, done_got, busy);
    else n_pass++;
  endtask

  initial begin
    rst            = 1'b1;
    cli_req        = '0;
    cli_addr       = '0;
    cli_len        = '0;
    mem_grant      = 1'b0;
    mem_data       = '0;
    mem_data_valid = 1'b0;
    for (int c = 0; c < NR; c++) rem[c] = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_zero_len();
    test_overrun();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0 || sb.size() != 0)
      $display("FAIL final_drain: got %0d grants %0d beats pending, required 0 0", exp_q.size(), sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time: simulation still running, required finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
